// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with exception sequencing and stall watchdog
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h00000040,
  parameter logic [31:0] ERET_CODE     = 32'h0000000e,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        stall_i_clr,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cycles_o,
  output logic        stall_timeout_o
);

  localparam int unsigned RW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          capture;
  logic [5:0]    stall_req;
  logic [31:0]   new_pc_q, new_pc_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [RW-1:0] run_q, run_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem_i)     stall_req = 6'b011111;
    else if (stallreq_ex_i) stall_req = 6'b001111;
    else if (stallreq_id_i) stall_req = 6'b000111;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 6'b000000;
    capture = 1'b0;
    case (state_q)
      RUN: begin
        if (excepttype_i != 32'h0) begin
          stall_o = 6'b111111;
          capture = 1'b1;
          state_d = FLUSH;
        end else begin
          stall_o = stall_req;
        end
      end
      FLUSH:   state_d = RECOVER;
      RECOVER: begin
        // Codes still visible here belong to already-flushed instructions.
        stall_o = stall_req;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!rst) begin
      stall_o = 6'b000000;
      capture = 1'b0;
    end
  end

  always_comb begin
    new_pc_d = new_pc_q;
    if (capture) new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
  end

  always_comb begin
    cycles_d  = cycles_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    if (stall_i_clr) begin
      cycles_d  = 32'h0;
      run_d     = '0;
      timeout_d = 1'b0;
    end else begin
      if (stall_o != 6'b000000) begin
        if (cycles_q != 32'hFFFFFFFF) cycles_d = cycles_q + 32'd1;
        if (run_q != RUN_MAX)         run_d    = run_q + RW'(1);
      end else begin
        run_d = '0;
      end
      // Flag rises with the edge that completes the run so it is visible one cycle later.
      if (run_d == RUN_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      new_pc_q  <= 32'h0;
      cycles_q  <= 32'h0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      cycles_q  <= cycles_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush_o         = (state_q == FLUSH);
  assign new_pc_o        = new_pc_q;
  assign stall_cycles_o  = cycles_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall and flush controller for the six-stage in-order pipeline (PC, IF, ID, EX, MEM, WB). It produces the `stall` vector consumed by every pipeline register, including the ID/EX register. It also sequences exception and ERET flushes through a small state machine and supplies the redirect PC. It keeps stall-cycle performance counters and raises a sticky watchdog flag when the pipeline stays stalled too long.

## Interface

**Parameters**

- `EXC_VECTOR`, default 32'h00000040: redirect target for every non-ERET exception.
- `ERET_CODE`, default 32'h0000000e: `excepttype_i` value that denotes ERET.
- `STALL_TIMEOUT`, default 1024: number of consecutive stalled cycles that sets the watchdog flag; legal range 2..2^16.

**Ports** (all synchronous to `clk`)

- `clk`, in, 1: clock. One clock domain; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-low.
- `stallreq_id_i`, in, 1: ID stage stall request (load-use).
- `stallreq_ex_i`, in, 1: EX stage stall request (multi-cycle ALU op).
- `stallreq_mem_i`, in, 1: MEM stage stall request (data bus wait).
- `excepttype_i`, in, 32: exception code from MEM; 0 means none.
- `cp0_epc_i`, in, 32: CP0 EPC, used for ERET.
- `stall_i_clr`, in, 1: clears the counters and the watchdog flag.
- `stall_o`, out, 6: bit k = 1 (Stop) freezes stage k. Bit 0 is PC and bit 5 is WB.
- `flush_o`, out, 1: flush all pipeline registers.
- `new_pc_o`, out, 32: redirect PC, valid while `flush_o` = 1.
- `stall_cycles_o`, out, 32: total stalled cycles, saturating.
- `stall_timeout_o`, out, 1: sticky watchdog flag.

## Operation

**State machine:** states RUN, FLUSH, RECOVER. Reset enters RUN.

- **RUN**
  - If `excepttype_i` != 0, capture the redirect PC: `cp0_epc_i` if `excepttype_i` == `ERET_CODE`, else `EXC_VECTOR`. Next state is FLUSH.
  - In that same detect cycle `stall_o` = 6'b111111, overriding every request.
- **FLUSH**
  - `flush_o` = 1, `stall_o` = 6'b000000, `new_pc_o` = captured value.
  - Stall requests and `excepttype_i` are ignored.
  - Next state is RECOVER.
- **RECOVER**
  - `excepttype_i` is ignored, which masks stale codes from flushed stages.
  - Stall priority is applied as in RUN.
  - Next state is RUN.

**Stall priority** (RUN without an exception, and RECOVER):

- `stallreq_mem_i` gives 6'b011111.
- else `stallreq_ex_i` gives 6'b001111.
- else `stallreq_id_i` gives 6'b000111.
- else 6'b000000.
- Lower-priority requests raised in the same cycle are subsumed by the higher one.

**Output decode:**

- `stall_o` is combinational from the state and the inputs.
- `flush_o` = (state == FLUSH) and is Moore only.
- `new_pc_o` is a register that holds its value until the next capture.

**Counters:**

- `stall_cycles_o` increments in every cycle with `stall_o` != 0, including the exception detect cycle. It saturates at 32'hFFFFFFFF.
- An internal run-length counter increments in every cycle with `stall_o` != 0 and resets to 0 in any cycle with `stall_o` == 0. It saturates at `STALL_TIMEOUT`.
- `stall_timeout_o` sets when the run-length counter reaches `STALL_TIMEOUT` and stays set until cleared.
- `stall_i_clr` = 1 clears `stall_cycles_o`, the run-length counter and `stall_timeout_o` at the next edge. Clear has priority over increment in the same cycle.

**Reset** (`rst` = 0 at an edge), effective the following cycle:

- state RUN
- `stall_o` = 0 and `flush_o` = 0
- `new_pc_o` = 32'h0
- `stall_cycles_o` = 0, run-length counter = 0, `stall_timeout_o` = 0

While `rst` is low, `stall_o` is forced to 0. Reset during FLUSH or RECOVER aborts the sequence with no further `flush_o` pulse.

## Timing

- **Stall:** zero latency. A request in cycle N is reflected in `stall_o` in cycle N.
- **Exception:** detected in cycle N. `stall_o` = 6'b111111 in N. `flush_o` and `new_pc_o` are valid in N+1 for exactly one cycle. Cycle N+2 is RECOVER. The earliest next accepted exception is in N+3.
- **Back-to-back:** an exception presented only during N+1 or N+2 is dropped. MEM must re-present any exception that is still pending in N+3.
- **Counters:** visible one cycle after the counted cycle. `stall_timeout_o` is first high in the cycle after the `STALL_TIMEOUT`-th consecutive stalled cycle.

## Test plan

- **Stall priority:** `stallreq_id_i` = 1 and `stallreq_mem_i` = 1 in the same cycle -> `stall_o` = 6'b011111. Only `stallreq_id_i` = 1 -> 6'b000111. No requests -> 6'b000000.
- **Exception redirect:** `excepttype_i` = 32'h1 with `stallreq_ex_i` = 1 at cycle N -> N: `stall_o` = 6'b111111. N+1: `flush_o` = 1, `new_pc_o` = 32'h40, `stall_o` = 0. N+2: `excepttype_i` still 1 but `flush_o` = 0 and no capture. N+3: accepted again.
- **ERET redirect:** `excepttype_i` = 32'he, `cp0_epc_i` = 32'hBFC00100 -> `new_pc_o` = 32'hBFC00100 with `flush_o` = 1 one cycle later.
- **Watchdog and clear:** `STALL_TIMEOUT` = 16, `stallreq_ex_i` held for 16 cycles from a cleared start -> `stall_timeout_o` = 1 in cycle 17 and `stall_cycles_o` = 16. Then `stall_i_clr` = 1 while still stalled -> both read 0 next cycle and the counters restart.
- **Watchdog run reset:** 15 stalled cycles, 1 idle cycle, then 15 stalled cycles -> `stall_timeout_o` stays 0 and `stall_cycles_o` = 30.
- **Reset mid-flush:** `rst` = 0 at the edge entering N+1 of an exception -> `flush_o` = 0, `new_pc_o` = 0, state RUN, `stall_o` = 0.
